// File: rtl/vram_paint_engine_pkg.sv
// paint_pkg: shared types, colours and clipping helpers for the VRAM paint engine
package paint_pkg;
  localparam int CW = 9;
  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PAINT} state_t;
  typedef struct packed {
    logic valid;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } touch_t;
  typedef logic [15:0] ILI9341_color_t;
  localparam ILI9341_color_t WHITE = 16'hFFFF;
  localparam ILI9341_color_t RED = 16'hF800;
  localparam ILI9341_color_t GREEN = 16'h07E0;
  typedef struct packed {
    logic [CW-1:0] x0;
    logic [CW-1:0] x1;
    logic [CW-1:0] y0;
    logic [CW-1:0] y1;
  } box_t;
  function automatic logic [CW-1:0] clip_lo(input logic [CW-1:0] v, input logic [CW-1:0] r);
    return v >= r ? v - r : '0;
  endfunction
  function automatic logic [CW-1:0] clip_hi(input logic [CW-1:0] v, input logic [CW-1:0] r, input logic [CW-1:0] m);
    return ({1'b0, v} + {1'b0, r} > {1'b0, m}) ? m : v + r;
  endfunction
endpackage

// File: rtl/vram_paint_engine_rr_arbiter.sv
// rr_arbiter: grants the first requester at or after ptr
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input logic [N-1:0] req,
  input logic [IW-1:0] ptr,
  output logic gnt_valid,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] j;
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx = j;
      end
    end
  end
endmodule

// File: rtl/vram_paint_engine.sv
// vram_paint_engine: clears the frame buffer and paints clipped square brushes per touch channel
module vram_paint_engine
  import paint_pkg::*;
#(
  parameter int WIDTH = 240,
  parameter int HEIGHT = 320,
  parameter int COLOR_W = 16,
  parameter int N_TOUCH = 2,
  parameter int BRUSH_MAX = 7,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = COLOR_W'(GREEN),
  localparam int VRAM_L = WIDTH * HEIGHT,
  localparam int AW = $clog2(VRAM_L),
  localparam int BW = $clog2(BRUSH_MAX + 1)
) (
  input logic clk,
  input logic rst,
  input logic clear_req,
  input logic [COLOR_W-1:0] clear_color,
  input logic [BW-1:0] brush_radius,
  input touch_t [N_TOUCH-1:0] touch,
  input logic [N_TOUCH-1:0][COLOR_W-1:0] ink_color,
  output logic vram_wr_ena,
  output logic [AW-1:0] vram_wr_addr,
  output logic [COLOR_W-1:0] vram_wr_data,
  output logic clearing,
  output logic busy
);
  localparam int IW = N_TOUCH > 1 ? $clog2(N_TOUCH) : 1;
  state_t state_q, state_d;
  logic [AW-1:0] pa_q, pa_d, rb_q, rb_d, addr_q, addr_d;
  logic [CW-1:0] cx_q, cx_d, cy_q, cy_d, px_q, px_d, py_q, py_d, x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COLOR_W-1:0] fill_q, fill_d, ink_q, ink_d, data_q, data_d;
  logic [IW-1:0] gnt_q, gnt_d, rr_q, rr_d, gnt_idx;
  logic done_q, done_d, ena_q, ena_d, gnt_valid;
  logic [N_TOUCH-1:0] lv_q, lv_d, pend, val;
  logic [N_TOUCH-1:0][CW-1:0] lx_q, lx_d, ly_q, ly_d;
  logic [CW-1:0] rad;
  logic [AW-1:0] base;
  box_t gbox;
  assign vram_wr_ena = ena_q;
  assign vram_wr_addr = addr_q;
  assign vram_wr_data = data_q;
  assign clearing = state_q == S_CLEAR;
  assign busy = state_q != S_IDLE;
  rr_arbiter #(.N(N_TOUCH)) u_arb (.req(pend), .ptr(rr_q), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx));
  always_comb begin
    pend = '0;
    val = '0;
    for (int i = 0; i < N_TOUCH; i++) begin
      val[i] = touch[i].valid;
      pend[i] = touch[i].valid && ({1'b0, touch[i].x} < (CW+1)'(WIDTH)) && ({1'b0, touch[i].y} < (CW+1)'(HEIGHT))
        && (!lv_q[i] || touch[i].x != lx_q[i] || touch[i].y != ly_q[i]);
    end
  end
  always_comb begin
    rad = CW'((int'(brush_radius) > BRUSH_MAX) ? BRUSH_MAX : int'(brush_radius));
    gbox.x0 = clip_lo(touch[gnt_idx].x, rad);
    gbox.x1 = clip_hi(touch[gnt_idx].x, rad, CW'(WIDTH - 1));
    gbox.y0 = clip_lo(touch[gnt_idx].y, rad);
    gbox.y1 = clip_hi(touch[gnt_idx].y, rad, CW'(HEIGHT - 1));
    base = AW'(gbox.y0) * AW'(WIDTH) + AW'(gbox.x0);
  end
  always_comb begin
    state_d = state_q;
    pa_d = pa_q;
    rb_d = rb_q;
    cx_d = cx_q;
    cy_d = cy_q;
    px_d = px_q;
    py_d = py_q;
    x0_d = x0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    fill_d = fill_q;
    ink_d = ink_q;
    gnt_d = gnt_q;
    rr_d = rr_q;
    done_d = done_q;
    lv_d = lv_q & val;
    lx_d = lx_q;
    ly_d = ly_q;
    ena_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (clear_req) begin
      state_d = S_CLEAR;
      fill_d = clear_color;
      ena_d = 1'b1;
      addr_d = '0;
      data_d = clear_color;
      pa_d = AW'(1);
      done_d = 1'b0;
    end else if (state_q == S_CLEAR) begin
      if (done_q) state_d = S_IDLE;
      else begin
        ena_d = 1'b1;
        addr_d = pa_q;
        data_d = fill_q;
        done_d = pa_q == AW'(VRAM_L - 1);
        pa_d = pa_q + 1'b1;
      end
    end else if (state_q == S_IDLE) begin
      if (gnt_valid) begin
        state_d = S_PAINT;
        gnt_d = gnt_idx;
        px_d = touch[gnt_idx].x;
        py_d = touch[gnt_idx].y;
        ink_d = ink_color[gnt_idx];
        x0_d = gbox.x0;
        x1_d = gbox.x1;
        y1_d = gbox.y1;
        cx_d = gbox.x0;
        cy_d = gbox.y0;
        pa_d = base;
        rb_d = base;
        done_d = 1'b0;
      end
    end else if (done_q) begin
      state_d = S_IDLE;
      lv_d[gnt_q] = 1'b1;
      lx_d[gnt_q] = px_q;
      ly_d[gnt_q] = py_q;
      rr_d = gnt_q == IW'(N_TOUCH - 1) ? '0 : gnt_q + 1'b1;
    end else begin
      ena_d = 1'b1;
      addr_d = pa_q;
      data_d = ink_q;
      if (cx_q != x1_q) begin
        cx_d = cx_q + 1'b1;
        pa_d = pa_q + 1'b1;
      end else if (cy_q == y1_q) done_d = 1'b1;
      else begin
        cx_d = x0_q;
        cy_d = cy_q + 1'b1;
        rb_d = rb_q + AW'(WIDTH);
        pa_d = rb_q + AW'(WIDTH);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      pa_q <= '0;
      rb_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      px_q <= '0;
      py_q <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      fill_q <= CLEAR_COLOR;
      ink_q <= '0;
      gnt_q <= '0;
      rr_q <= '0;
      done_q <= 1'b0;
      lv_q <= '0;
      lx_q <= '0;
      ly_q <= '0;
      ena_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      pa_q <= pa_d;
      rb_q <= rb_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      px_q <= px_d;
      py_q <= py_d;
      x0_q <= x0_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      fill_q <= fill_d;
      ink_q <= ink_d;
      gnt_q <= gnt_d;
      rr_q <= rr_d;
      done_q <= done_d;
      lv_q <= lv_d;
      lx_q <= lx_d;
      ly_q <= ly_d;
      ena_q <= ena_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_vram_paint_engine.sv
// tb_vram_paint_engine: directed and random paint/clear scenarios checked against a pixel-list model
module tb_vram_paint_engine;
  import paint_pkg::*;
  localparam int W = 240;
  localparam int H = 64;
  localparam int AW = $clog2(W * H);
  logic clk = 1'b0;
  logic rst, clear_req, vram_wr_ena, clearing, busy;
  logic [15:0] clear_color, vram_wr_data;
  logic [2:0] brush_radius;
  logic [AW-1:0] vram_wr_addr;
  touch_t [1:0] touch;
  logic [1:0][15:0] ink_color;
  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
    int c;
  } wr_t;
  wr_t wq[$];
  wr_t ex[$];
  wr_t w;
  int cyc = 0, tests = 0, fails = 0;
  bit m_lv[2];
  int m_lx[2], m_ly[2], m_rr = 0;
  bit tv[2];
  int tx[2], ty[2], br = 0;
  logic [15:0] ti[2];
  always #5 clk = ~clk;
  vram_paint_engine #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .clear_color(clear_color), .brush_radius(brush_radius),
    .touch(touch), .ink_color(ink_color), .vram_wr_ena(vram_wr_ena), .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data), .clearing(clearing), .busy(busy)
  );
  always @(posedge clk) begin
    #1;
    cyc++;
    if (vram_wr_ena) begin
      w.a = 32'(vram_wr_addr);
      w.d = vram_wr_data;
      w.c = cyc;
      wq.push_back(w);
    end
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic apply();
    for (int i = 0; i < 2; i++) begin
      touch[i].valid = tv[i];
      touch[i].x = 9'(tx[i]);
      touch[i].y = 9'(ty[i]);
      ink_color[i] = ti[i];
    end
    brush_radius = 3'(br);
  endtask
  function automatic bit pending(input int i);
    return tv[i] && tx[i] < W && ty[i] < H && (!m_lv[i] || tx[i] != m_lx[i] || ty[i] != m_ly[i]);
  endfunction
  task automatic add_brush(input int ch);
    int r, xlo, xhi, ylo, yhi;
    wr_t e;
    r = br > 7 ? 7 : br;
    xlo = tx[ch] - r < 0 ? 0 : tx[ch] - r;
    xhi = tx[ch] + r > W - 1 ? W - 1 : tx[ch] + r;
    ylo = ty[ch] - r < 0 ? 0 : ty[ch] - r;
    yhi = ty[ch] + r > H - 1 ? H - 1 : ty[ch] + r;
    for (int yy = ylo; yy <= yhi; yy++)
      for (int xx = xlo; xx <= xhi; xx++) begin
        e.a = 32'(yy * W + xx);
        e.d = ti[ch];
        e.c = 0;
        ex.push_back(e);
      end
  endtask
  task automatic model_serve();
    int f;
    for (int i = 0; i < 2; i++) if (!tv[i]) m_lv[i] = 0;
    for (int n = 0; n < 2; n++) begin
      f = -1;
      for (int k = 0; k < 2; k++) if (f < 0 && pending((m_rr + k) % 2)) f = (m_rr + k) % 2;
      if (f >= 0) begin
        add_brush(f);
        m_lv[f] = 1;
        m_lx[f] = tx[f];
        m_ly[f] = ty[f];
        m_rr = (f + 1) % 2;
      end
    end
  endtask
  task automatic compare_writes(input string tag);
    check({tag, "_count"}, 64'(wq.size()), 64'(ex.size()));
    for (int i = 0; i < wq.size() && i < ex.size(); i++)
      check({tag, "_pix"}, {wq[i].a, wq[i].d}, {ex[i].a, ex[i].d});
  endtask
  task automatic step(input int waitc, input string tag);
    int c0;
    wq.delete();
    ex.delete();
    apply();
    c0 = cyc;
    model_serve();
    repeat (waitc) @(negedge clk);
    compare_writes(tag);
    if (wq.size() > 0 && ex.size() > 0) check({tag, "_lat"}, 64'(wq[0].c), 64'(c0 + 2));
    check({tag, "_busy"}, 64'(busy), 0);
  endtask
  task automatic wait_clear(input string tag);
    int k = 0;
    while (clearing && k < 2 * W * H) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, 64'(clearing), 0);
  endtask
  task automatic check_sweep(input string tag, input int from, input logic [15:0] col);
    int bad = 0;
    for (int i = from; i < wq.size(); i++) if (wq[i].a != 32'(i - from) || wq[i].d !== col) bad++;
    check({tag, "_count"}, 64'(wq.size() - from), 64'(W * H));
    check({tag, "_bad"}, 64'(bad), 0);
  endtask
  initial begin
    int c0, n0;
    rst = 1'b1;
    clear_req = 1'b0;
    clear_color = '0;
    for (int i = 0; i < 2; i++) begin
      tv[i] = 0;
      tx[i] = 0;
      ty[i] = 0;
      ti[i] = '0;
    end
    apply();
    repeat (3) @(negedge clk);
    check("rst_ena", 64'(vram_wr_ena), 0);
    check("rst_addr", 64'(vram_wr_addr), 0);
    check("rst_data", 64'(vram_wr_data), 0);
    check("rst_clearing", 64'(clearing), 1);
    check("rst_busy", 64'(busy), 1);
    rst = 1'b0;
    c0 = cyc;
    wq.delete();
    wait_clear("clr");
    check("clr_fall", 64'(cyc), 64'(c0 + W * H + 1));
    if (wq.size() > 0) check("clr_first", 64'(wq[0].c), 64'(c0 + 1));
    check_sweep("clr", 0, GREEN);
    check("clr_busy", 64'(busy), 0);
    tv[0] = 1; tx[0] = 100; ty[0] = 50; br = 0; ti[0] = WHITE;
    step(110, "single");
    check("single_idle_ena", 64'(vram_wr_ena), 0);
    tx[0] = 0; ty[0] = 0; br = 2; ti[0] = 16'h001F;
    step(40, "corner");
    tv[1] = 1; tx[1] = 200; ty[1] = 30; br = 1; ti[1] = 16'hFFE0;
    step(40, "ch1_only");
    tx[0] = W - 1; ty[0] = H - 1; tx[1] = 10; ty[1] = 10;
    step(60, "dual");
    if (wq.size() >= 5) check("dual_gap", 64'(wq[4].c - wq[3].c), 3);
    tx[0] = W - 2; ty[0] = H - 2;
    step(40, "move0");
    tx[0] = W - 3; ty[0] = H - 3; tx[1] = 11; ty[1] = 11;
    step(60, "rr_swap");
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 2; i++) begin
        tv[i] = $urandom_range(0, 9) < 8;
        tx[i] = $urandom_range(0, W + 19);
        ty[i] = $urandom_range(0, H + 19);
        ti[i] = 16'($urandom);
      end
      br = $urandom_range(0, 7);
      step(520, "rand");
    end
    tv[0] = 1; tx[0] = W; ty[0] = 20; tv[1] = 0;
    step(50, "x_oob");
    tx[0] = 120; ty[0] = 30; br = 7; ti[0] = 16'h1234;
    step(260, "rmax");
    tx[0] = 121;
    wq.delete();
    ex.delete();
    apply();
    model_serve();
    repeat (100) @(negedge clk);
    n0 = wq.size();
    check("abort_prefix_count", 64'(n0), 99);
    for (int i = 0; i < n0 && i < ex.size(); i++) check("abort_prefix", {wq[i].a, wq[i].d}, {ex[i].a, ex[i].d});
    clear_req = 1'b1;
    clear_color = RED;
    @(negedge clk);
    clear_req = 1'b0;
    check("abort_next_count", 64'(wq.size()), 64'(n0 + 1));
    if (wq.size() > n0) check("abort_next", {wq[n0].a, wq[n0].d}, {32'd0, RED});
    check("abort_clearing", 64'(clearing), 1);
    wait_clear("reclr");
    check_sweep("reclr", n0, RED);
    wq.delete();
    repeat (260) @(negedge clk);
    compare_writes("repaint");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
